// File: rtl/horner_pkg.sv
// rtl/horner_pkg.sv - shared types and constants for the Horner polynomial sequencer
package horner_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_N       = 12;
  localparam int DEF_DEG     = 3;
  localparam int DEF_MUL_LAT = 4;

  // Q0.N constants for the default width
  localparam int SAT_MAX = (1 << DEF_N) - 1;
  localparam int RND_BIT = DEF_N - 1;

  // Width of the wait counter, which must reach MUL_LAT itself
  function automatic int wcnt_width(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/horner_poly_seq_if.sv
// rtl/horner_poly_seq_if.sv - request/result handshake bundle of the Horner sequencer
interface horner_poly_seq_if #(
  parameter int N   = 12,
  parameter int DEG = 3
);

  logic                   start;
  logic [N-1:0]           x;
  logic [(DEG+1)*N-1:0]   coeff;
  logic                   busy;
  logic                   done;
  logic [N-1:0]           y;

  modport master (output start, output x, output coeff, input busy, input done, input y);
  modport slave  (input start, input x, input coeff, output busy, output done, output y);

endinterface

// File: rtl/horner_rescale_sat.sv
// rtl/horner_rescale_sat.sv - rounds a 2N-bit product back to Q0.N and adds a coefficient with saturation
module horner_rescale_sat #(
  parameter int N = 12
) (
  input  logic [2*N-1:0] p,
  input  logic [N-1:0]   c,
  output logic [N-1:0]   y
);

  localparam logic [N+1:0] SAT = {2'b00, {N{1'b1}}};

  logic [N:0]   r;
  logic [N+1:0] s;

  // The bits below the rounding bit only matter through the round-half-up rule
  wire unused_low = ^p[N-2:0];

  // Round half up, add coefficient, clamp to the largest Q0.N value
  always_comb begin
    r = {1'b0, p[2*N-1:N]} + {{N{1'b0}}, p[N-1]};
    s = {1'b0, r} + {2'b00, c};
    y = (s > SAT) ? SAT[N-1:0] : s[N-1:0];
  end

endmodule

// File: rtl/r4booth_even.sv
// rtl/r4booth_even.sv - pipelined unsigned radix-4 Booth multiplier, falling-edge clocked
module r4booth_even #(
  parameter int N = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);

  localparam int DIG = (N + 2) / 2;
  localparam int H   = DIG / 2;
  localparam int W   = 2 * N + 3;

  logic [N-1:0]          a_r;
  logic [N-1:0]          b_r;
  logic [N+2:0]          bx;
  logic signed [W-1:0]   am;
  logic signed [W-1:0]   pp_c [DIG];
  logic signed [W-1:0]   pp_r [DIG];
  logic signed [W-1:0]   sum_lo_c;
  logic signed [W-1:0]   sum_hi_c;
  logic signed [W-1:0]   sum_lo_r;
  logic signed [W-1:0]   sum_hi_r;
  logic signed [W-1:0]   total;

  wire unused_total_hi = ^total[W-1:2*N];

  // Operand capture: first edge after the operands are launched
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      a_r <= '0;
      b_r <= '0;
    end else begin
      a_r <= a;
      b_r <= b;
    end
  end

  // Booth recoding of the zero-extended multiplier into signed partial products
  always_comb begin
    bx = {2'b00, b_r, 1'b0};
    am = signed'({{(W-N){1'b0}}, a_r});
    for (int i = 0; i < DIG; i++) begin
      case (bx[2*i +: 3])
        3'b001, 3'b010: pp_c[i] = am <<< (2 * i);
        3'b011:         pp_c[i] = (am <<< 1) <<< (2 * i);
        3'b100:         pp_c[i] = (-(am <<< 1)) <<< (2 * i);
        3'b101, 3'b110: pp_c[i] = (-am) <<< (2 * i);
        default:        pp_c[i] = '0;
      endcase
    end
  end

  // Split reduction of the registered partial products into two halves
  always_comb begin
    sum_lo_c = '0;
    sum_hi_c = '0;
    for (int i = 0; i < DIG; i++) begin
      if (i < H) sum_lo_c = sum_lo_c + pp_r[i];
      else       sum_hi_c = sum_hi_c + pp_r[i];
    end
    total = sum_lo_r + sum_hi_r;
  end

  // Pipeline: partial products, half sums, then the product register
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DIG; i++) pp_r[i] <= '0;
      sum_lo_r <= '0;
      sum_hi_r <= '0;
      p        <= '0;
    end else begin
      for (int i = 0; i < DIG; i++) pp_r[i] <= pp_c[i];
      sum_lo_r <= sum_lo_c;
      sum_hi_r <= sum_hi_c;
      p        <= total[2*N-1:0];
    end
  end

endmodule

// File: rtl/horner_poly_seq.sv
// rtl/horner_poly_seq.sv - Horner-rule polynomial sequencer driving an external multiplier
module horner_poly_seq
  import horner_pkg::*;
#(
  parameter int N       = 12,
  parameter int DEG     = 3,
  parameter int MUL_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  horner_poly_seq_if.slave bus,
  output logic [N-1:0]     mul_a,
  output logic [N-1:0]     mul_b,
  input  logic [2*N-1:0]   mul_p
);

  localparam int CW = (DEG + 1) * N;
  localparam int SW = (DEG < 2) ? 1 : $clog2(DEG + 1);
  localparam int WW = wcnt_width(MUL_LAT);

  localparam logic [SW-1:0] STEP_INIT = SW'(DEG);
  localparam logic [SW-1:0] STEP_LAST = SW'(1);
  localparam logic [WW-1:0] WCNT_LAST = WW'(MUL_LAT);

  state_t          state;
  state_t          next_state;
  logic            accept;
  logic            launch;
  logic            capture;
  logic            finish;

  logic [N-1:0]    x_r;
  logic [CW-1:0]   coeff_r;
  logic [N-1:0]    acc;
  logic [SW-1:0]   step;
  logic [WW-1:0]   wcnt;
  logic [N-1:0]    c_sel;
  logic [N-1:0]    acc_next;
  logic [N-1:0]    y_r;
  logic            done_r;

  assign bus.busy = (state != IDLE);
  assign bus.done = done_r;
  assign bus.y    = y_r;

  // Coefficient c_(step-1) for the capture currently in flight
  always_comb begin
    c_sel = '0;
    for (int k = 0; k < DEG; k++) begin
      if (step == SW'(k + 1)) c_sel = coeff_r[k*N +: N];
    end
  end

  horner_rescale_sat #(.N(N)) u_rescale (
    .p (mul_p),
    .c (c_sel),
    .y (acc_next)
  );

  // Next-state and per-edge action strobes
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    launch     = 1'b0;
    capture    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        launch     = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        if (wcnt == WCNT_LAST) begin
          capture    = 1'b1;
          next_state = (step == STEP_LAST) ? DONE : ISSUE;
        end
      end
      DONE: begin
        finish     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register, same falling edge as the multiplier
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Operand latch, accumulator, step/wait counters, operand launch and result
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      x_r     <= '0;
      coeff_r <= '0;
      acc     <= '0;
      step    <= '0;
      wcnt    <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      y_r     <= '0;
      done_r  <= 1'b0;
    end else begin
      done_r <= finish;
      if (accept) begin
        x_r     <= bus.x;
        coeff_r <= bus.coeff;
        acc     <= bus.coeff[DEG*N +: N];
        step    <= STEP_INIT;
      end
      if (launch) begin
        mul_a <= acc;
        mul_b <= x_r;
        wcnt  <= '0;
      end else if (state == WAIT && !capture) begin
        wcnt <= wcnt + 1'b1;
      end
      if (capture) begin
        acc  <= acc_next;
        step <= step - 1'b1;
      end
      if (finish) y_r <= acc;
    end
  end

endmodule

// File: tb/tb_horner_poly_seq.sv
// tb/tb_horner_poly_seq.sv - self-checking bench for horner_poly_seq with the Booth multiplier
module tb_horner_poly_seq;

  localparam int N   = 12;
  localparam int DEG = 3;
  localparam int CW  = (DEG + 1) * N;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   mul_a;
  logic [N-1:0]   mul_b;
  logic [2*N-1:0] mul_p;

  int n_checks = 0;
  int n_fail   = 0;

  horner_poly_seq_if #(.N(N), .DEG(DEG)) bus ();

  horner_poly_seq #(.N(N), .DEG(DEG), .MUL_LAT(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .mul_a (mul_a),
    .mul_b (mul_b),
    .mul_p (mul_p)
  );

  r4booth_even #(.N(N)) u_mul (
    .clk (clk),
    .rst (rst),
    .a   (mul_a),
    .b   (mul_b),
    .p   (mul_p)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] pack(input logic [N-1:0] c3, input logic [N-1:0] c2,
                                         input logic [N-1:0] c1, input logic [N-1:0] c0);
    return {c3, c2, c1, c0};
  endfunction

  function automatic logic [CW-1:0] rand_coeff();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    return v[CW-1:0];
  endfunction

  // y = c_DEG x^DEG + ... + c0 by Horner with round-half-up rescale and clamp
  function automatic logic [N-1:0] ref_model(input logic [N-1:0] xv, input logic [CW-1:0] cv);
    longint acc;
    longint prod;
    longint s;
    longint lim;
    lim = (longint'(1) << N) - 1;
    acc = longint'(cv[DEG*N +: N]);
    for (int k = DEG - 1; k >= 0; k--) begin
      prod = acc * longint'(xv);
      s    = ((prod + (longint'(1) << (N - 1))) >> N) + longint'(cv[k*N +: N]);
      acc  = (s > lim) ? lim : s;
    end
    return acc[N-1:0];
  endfunction

  task automatic do_eval(input string tag, input logic [N-1:0] xv, input logic [CW-1:0] cv,
                         input bit poke);
    int lat;
    int dones;
    bit busy_ok;
    logic [N-1:0] exp;
    exp = ref_model(xv, cv);
    @(posedge clk);
    bus.x     = xv;
    bus.coeff = cv;
    bus.start = 1'b1;
    @(negedge clk);
    @(posedge clk);
    bus.start = 1'b0;
    bus.x     = N'($urandom());
    bus.coeff = rand_coeff();
    lat = 0;
    dones = 0;
    busy_ok = 1'b1;
    while (dones == 0 && lat < 200) begin
      @(negedge clk);
      lat++;
      @(posedge clk);
      bus.start = 1'b0;
      if (poke && lat == 4) begin
        bus.start = 1'b1;
        bus.x     = N'($urandom());
        bus.coeff = rand_coeff();
      end
      if (bus.done) dones++;
      else if (!bus.busy) busy_ok = 1'b0;
    end
    check({tag, "_latency"}, lat, 19);
    check({tag, "_busy"}, 32'(busy_ok), 1);
    check({tag, "_y"}, 32'(bus.y), 32'(exp));
    repeat (4) begin
      @(negedge clk);
      @(posedge clk);
      if (bus.done) dones++;
    end
    check({tag, "_one_done"}, dones, 1);
    check({tag, "_idle_after"}, 32'(bus.busy), 0);
    check({tag, "_y_hold"}, 32'(bus.y), 32'(exp));
  endtask

  initial begin
    logic [CW-1:0] vec1;
    logic [CW-1:0] cv;
    int lat;
    int first;
    int second;

    vec1      = pack(12'h800, 12'h800, 12'h800, 12'h000);
    bus.start = 1'b0;
    bus.x     = '0;
    bus.coeff = '0;

    repeat (3) @(posedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_y", 32'(bus.y), 0);
    check("rst_mul_a", 32'(mul_a), 0);
    check("rst_mul_b", 32'(mul_b), 0);
    rst = 1'b1;

    do_eval("half", 12'h800, vec1, 1'b0);
    check("half_const", 32'(bus.y), 32'h700);

    do_eval("sat", 12'hFFF, pack(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF), 1'b0);
    check("sat_const", 32'(bus.y), 32'hFFF);

    do_eval("round", 12'h001, pack(12'h800, 12'h000, 12'h000, 12'h000), 1'b0);
    check("round_const", 32'(bus.y), 32'h000);

    cv = rand_coeff();
    cv[N-1:0] = 12'h123;
    do_eval("xzero", 12'h000, cv, 1'b0);
    check("xzero_const", 32'(bus.y), 32'h123);

    do_eval("poke", 12'h800, vec1, 1'b1);
    check("poke_const", 32'(bus.y), 32'h700);

    // start held high: back-to-back evaluations, second accepted right after DONE
    @(posedge clk);
    bus.x     = 12'h800;
    bus.coeff = vec1;
    bus.start = 1'b1;
    lat = 0;
    first = 0;
    second = 0;
    while (second == 0 && lat < 200) begin
      @(negedge clk);
      lat++;
      @(posedge clk);
      if (bus.done) begin
        if (first == 0) first = lat;
        else second = lat;
      end
    end
    bus.start = 1'b0;
    check("held_first", first, 20);
    check("held_second", second, 40);
    check("held_y", 32'(bus.y), 32'h700);
    repeat (3) @(posedge clk);
    check("held_idle", 32'(bus.busy), 0);

    // asynchronous reset mid-evaluation
    @(posedge clk);
    bus.x     = 12'h800;
    bus.coeff = vec1;
    bus.start = 1'b1;
    @(negedge clk);
    @(posedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("abort_pre_busy", 32'(bus.busy), 1);
    rst = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_done", 32'(bus.done), 0);
    check("abort_y", 32'(bus.y), 0);
    check("abort_mul_a", 32'(mul_a), 0);
    @(posedge clk);
    rst = 1'b1;
    do_eval("after_abort", 12'h800, vec1, 1'b0);
    check("after_abort_const", 32'(bus.y), 32'h700);

    for (int i = 0; i < 20; i++) begin
      do_eval($sformatf("rand%0d", i), N'($urandom()), rand_coeff(), (i % 5) == 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/horner_poly_seq.md
Name: horner_poly_seq

Overview:
- Sequencer that evaluates an unsigned fixed-point polynomial y = c_DEG*x^DEG + … + c1*x + c0 by Horner's rule.
- Sits directly around the 12-bit radix-4 Booth multiplier (r4booth_even). It drives that multiplier's operands and consumes its 24-bit product.
- Rescales each product back to Q0.N, adds the next coefficient with saturation, and repeats until y is ready.
- Forms the approximation-evaluation stage of the nonlinear approximation engine.

Parameters:
- N, 12, operand/coefficient/result width; Q0.N unsigned fraction.
- DEG, 3, polynomial degree; DEG ≥ 1.
- MUL_LAT, 4, falling edges from operand launch until the multiplier's product register loads.

Ports:
- clk  in  1  clock; all state updates on falling edge, same as multiplier.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled on falling edge in IDLE only.
- x  in  N  evaluation point, Q0.N; latched on accepted start.
- coeff  in  (DEG+1)*N  packed coefficients, c_k = coeff[(k+1)*N-1 : k*N]; latched on accepted start.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse; y is valid.
- y  out  N  result, Q0.N; holds until next completion.
- mul_a  out  N  multiplicand to multiplier (registered).
- mul_b  out  N  multiplier operand to multiplier (registered).
- mul_p  in  2N  product from multiplier.

Behaviour:
- Reset (rst low, async): state = IDLE; busy = 0, done = 0, y = 0, mul_a = 0, mul_b = 0; acc, step, wcnt = 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - On an edge with start = 1: latch x and coeff; acc ← c_DEG; step ← DEG; go to ISSUE.
  - start = 0: stay.
- ISSUE (launch edge): mul_a ← acc; mul_b ← x_r; wcnt ← 0; go to WAIT.
- WAIT:
  - Each edge with wcnt < MUL_LAT: wcnt ← wcnt+1.
  - Edge with wcnt == MUL_LAT (capture, the (MUL_LAT+1)th edge after launch): acc ← rs(mul_p) + c_(step-1), saturated; step ← step-1.
  - After capture: if step-1 == 0 go to DONE, else go to ISSUE.
- DONE: y ← acc; done ← 1 for exactly one cycle; return to IDLE.
- Arithmetic:
  - r = mul_p[2N-1:N] + mul_p[N-1] (round half up), computed N+1 bits wide.
  - s = r + c_k, computed N+2 bits wide.
  - If s > 2^N-1, result is 2^N-1; otherwise s[N-1:0].
  - All operands unsigned; no negative coefficients.
- Latency: start accepted at edge e0 → done high after edge e0 + 1 + DEG*(MUL_LAT+2). Defaults give e0+19.
- mul_a/mul_b hold their last launched values until the next ISSUE; the multiplier needs stable operands through the sampling edge.
- start while busy (including in DONE): ignored, no queuing.
- start held high continuously: a new evaluation is accepted on the first IDLE edge after DONE.
- rst asserted mid-evaluation: immediate abort to reset values. In-flight multiplier products are discarded by construction, because the next evaluation re-launches.
- x or coeff changing during busy: no effect on the current evaluation.

Decomposition:
- Package horner_pkg: state encoding (IDLE, ISSUE, WAIT, DONE); Q-format constants (SAT_MAX = 2^N-1, rounding-bit index N-1); wcnt width = clog2(MUL_LAT+1).
- Sub-module horner_rescale_sat: combinational round/add/saturate. Inputs: 2N product, N coefficient. Output: N result.
- Bench instantiates horner_poly_seq together with r4booth_even (N=12) connected through mul_a/mul_b/mul_p.

Test Plan:
- x=0x800, c3=c2=c1=0x800, c0=0x000 → intermediates 0xC00, 0xE00; y=0x700; done exactly 19 falling edges after the start edge; busy high throughout.
- x=0xFFF, all coeffs 0xFFF → first-step sum 0x1FFD saturates; y=0xFFF, no wrap.
- x=0x001, c3=0x800, others 0 → acc after step 1 = 0x001 (rounding bit set); final y=0x000.
- x=0x000, c0=0x123, other coeffs arbitrary → y=0x123.
- Pulse start again at edge e0+5 with different operands → ignored; first result unchanged, single done pulse.
- Assert rst at edge e0+10 → busy=0, done=0, y=0 immediately. Then a new start with the first vector gives y=0x700 with full latency.
